// File: rtl/hamming_enc_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : hamming_enc_arbiter (with helper hamming_encoder)                 |
// | Two-source arbiter feeding a shared Hamming(15,11) encoder and a one-entry |
// | output stage. Optional macro HAMMING_SECDED_EN adds overall parity bit 15. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+

module hamming_encoder (
  input  logic [10:0] data_i,
  output logic [14:0] code_o
);

  logic [14:0] w_spread;

  // Data bits placed at their codeword positions; parity slots (bits 0,1,3,7) left zero.
  assign w_spread = {data_i[0], data_i[1], data_i[2], data_i[3], data_i[4], data_i[5],
                     data_i[6], 1'b0, data_i[7], data_i[8], data_i[9], 1'b0,
                     data_i[10], 1'b0, 1'b0};

  assign code_o = {w_spread[14:8], ^(w_spread & 15'h7F00),
                   w_spread[6:4],  ^(w_spread & 15'h7870),
                   w_spread[2],    ^(w_spread & 15'h6664),
                                   ^(w_spread & 15'h5554)};

endmodule

module hamming_enc_arbiter #(
  parameter int FIXED_PRIO = 0,
  parameter int COUNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  input  logic [10:0]        req0_data,
  output logic               req0_ready,
  input  logic               req1_valid,
  input  logic [10:0]        req1_data,
  output logic               req1_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [15:0]        out_data,
  output logic               out_src,
  output logic [COUNT_W-1:0] cnt0,
  output logic [COUNT_W-1:0] cnt1
);

  localparam logic [0:0]         c_ST_EMPTY = 1'b0;
  localparam logic [0:0]         c_ST_FULL  = 1'b1;
  localparam logic [COUNT_W-1:0] c_CNT_MAX  = {COUNT_W{1'b1}};

  logic [0:0]         state_q, state_d;
  logic               last_grant_q;
  logic [15:0]        out_data_q;
  logic               out_src_q;
  logic [COUNT_W-1:0] cnt0_q, cnt1_q;

  logic        w_gnt_vld;
  logic        w_gnt;
  logic        w_slot_free;
  logic        w_accept;
  logic [10:0] w_sel_data;
  logic [14:0] w_code;
  logic        w_msb;

  // Ties go to the source that did not win last time, unless fixed priority is chosen.
  always_comb begin
    w_gnt_vld = req0_valid | req1_valid;
    w_gnt     = 1'b0;
    if (req0_valid && req1_valid) begin
      w_gnt = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant_q;
    end else if (req1_valid) begin
      w_gnt = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= c_ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_ST_EMPTY: state_d = w_accept ? c_ST_FULL : c_ST_EMPTY;
      c_ST_FULL:  state_d = (w_accept || !out_ready) ? c_ST_FULL : c_ST_EMPTY;
      default:    state_d = c_ST_EMPTY;
    endcase
  end

  always_comb begin
    out_valid   = (state_q == c_ST_FULL);
    w_slot_free = (state_q == c_ST_EMPTY) | out_ready;
    req0_ready  = w_slot_free & w_gnt_vld & ~w_gnt;
    req1_ready  = w_slot_free & w_gnt_vld & w_gnt;
  end

  assign w_accept   = (req0_valid & req0_ready) | (req1_valid & req1_ready);
  assign w_sel_data = w_gnt ? req1_data : req0_data;

  hamming_encoder u_enc (
    .data_i (w_sel_data),
    .code_o (w_code)
  );

`ifdef HAMMING_SECDED_EN
  assign w_msb = ^w_code;
`else
  assign w_msb = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_q   <= '0;
      out_src_q    <= 1'b0;
      last_grant_q <= 1'b1;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
    end else if (w_accept) begin
      out_data_q   <= {w_msb, w_code};
      out_src_q    <= w_gnt;
      last_grant_q <= w_gnt;
      if (!w_gnt && cnt0_q != c_CNT_MAX) begin
        cnt0_q <= cnt0_q + 1'b1;
      end
      if (w_gnt && cnt1_q != c_CNT_MAX) begin
        cnt1_q <= cnt1_q + 1'b1;
      end
    end
  end

  assign out_data = out_data_q;
  assign out_src  = out_src_q;
  assign cnt0     = cnt0_q;
  assign cnt1     = cnt1_q;

endmodule

`default_nettype wire

// File: tb/tb_hamming_enc_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_hamming_enc_arbiter                                            |
// | Scoreboard bench: round-robin/16-bit and fixed-priority/2-bit instances.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_hamming_enc_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid, out_ready;
  logic [10:0] req0_data, req1_data;

  logic        r0_rdy  [2];
  logic        r1_rdy  [2];
  logic        o_valid [2];
  logic        o_src   [2];
  logic [15:0] o_data  [2];
  logic [15:0] o_cnt0  [2];
  logic [15:0] o_cnt1  [2];
  logic [1:0]  fp_cnt0, fp_cnt1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hamming_enc_arbiter #(.FIXED_PRIO(0), .COUNT_W(16)) u_rr (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(r0_rdy[0]),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(r1_rdy[0]),
    .out_valid(o_valid[0]), .out_ready(out_ready), .out_data(o_data[0]),
    .out_src(o_src[0]), .cnt0(o_cnt0[0]), .cnt1(o_cnt1[0])
  );

  hamming_enc_arbiter #(.FIXED_PRIO(1), .COUNT_W(2)) u_fp (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(r0_rdy[1]),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(r1_rdy[1]),
    .out_valid(o_valid[1]), .out_ready(out_ready), .out_data(o_data[1]),
    .out_src(o_src[1]), .cnt0(fp_cnt0), .cnt1(fp_cnt1)
  );

  assign o_cnt0[1] = {14'b0, fp_cnt0};
  assign o_cnt1[1] = {14'b0, fp_cnt1};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Codeword built from the positional rule: data fills non-power-of-two positions,
  // parity 2^k covers every position whose index has bit k set.
  function automatic logic [15:0] ref_enc(input logic [10:0] v);
    logic [15:0] cw;
    logic        par;
    int          di;
    cw = '0;
    di = 10;
    for (int p = 1; p <= 15; p++) begin
      if ((p & (p - 1)) != 0) begin
        cw[p-1] = v[di];
        di--;
      end
    end
    for (int k = 0; k < 4; k++) begin
      par = 1'b0;
      for (int p = 1; p <= 15; p++) begin
        if (((p & (p - 1)) != 0) && (((p >> k) & 1) != 0)) par ^= cw[p-1];
      end
      cw[(1 << k) - 1] = par;
    end
`ifdef HAMMING_SECDED_EN
    cw[15] = ^cw[14:0];
`endif
    return cw;
  endfunction

  for (genvar k = 0; k < 2; k++) begin : g_mon
    localparam int CMAX = (k == 0) ? 65535 : 3;
    logic [16:0] sbq[$];
    int lg, c0, c1;

    always @(negedge clk) begin : mon
      bit g, gv, free, e0, e1;
      if (rst) begin
        sbq.delete();
        lg = 1;
        c0 = 0;
        c1 = 0;
      end else begin
        chk("out_valid", o_valid[k], sbq.size() != 0);
        if (sbq.size() != 0) begin
          chk("out_data", o_data[k], sbq[0][15:0]);
          chk("out_src", o_src[k], sbq[0][16]);
        end
        chk("cnt0", o_cnt0[k], c0);
        chk("cnt1", o_cnt1[k], c1);
        gv = req0_valid || req1_valid;
        if (req0_valid && req1_valid) g = (k == 1) ? 1'b0 : (lg == 0);
        else g = !req0_valid;
        free = (sbq.size() == 0) || out_ready;
        e0 = free && gv && !g;
        e1 = free && gv && g;
        chk("req0_ready", r0_rdy[k], e0);
        chk("req1_ready", r1_rdy[k], e1);
        if (sbq.size() != 0 && out_ready) void'(sbq.pop_front());
        if (e0 || e1) begin
          sbq.push_back({g, g ? ref_enc(req1_data) : ref_enc(req0_data)});
          lg = g ? 1 : 0;
          if (g) c1 = (c1 < CMAX) ? c1 + 1 : c1;
          else   c0 = (c0 < CMAX) ? c0 + 1 : c0;
        end
      end
    end
  end

  task automatic cycle_rand(input int pv);
    @(posedge clk); #1;
    req0_valid = ($urandom_range(99) < pv);
    req1_valid = ($urandom_range(99) < pv);
    req0_data  = 11'($urandom);
    req1_data  = 11'($urandom);
    out_ready  = ($urandom_range(3) != 0);
  endtask

  logic [10:0] dw [3];
  logic [15:0] dx [3];

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = '0; req1_data = '0;
    out_ready = 1'b1;
    #2;
    for (int k = 0; k < 2; k++) begin
      chk("rst_out_valid", o_valid[k], 0);
      chk("rst_out_data", o_data[k], 0);
      chk("rst_out_src", o_src[k], 0);
      chk("rst_cnt0", o_cnt0[k], 0);
      chk("rst_cnt1", o_cnt1[k], 0);
    end
    #10 rst = 1'b0;

    // Single source, known codewords
    dw[0] = 11'h000; dw[1] = 11'h400; dw[2] = 11'h001;
`ifdef HAMMING_SECDED_EN
    dx[0] = 16'h0000; dx[1] = 16'h8007; dx[2] = 16'hC08B;
`else
    dx[0] = 16'h0000; dx[1] = 16'h0007; dx[2] = 16'h408B;
`endif
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_data = dw[0];
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (i < 2) req0_data = dw[i+1];
      else       req0_valid = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        chk("directed_code", o_data[k], dx[i]);
        chk("directed_src", o_src[k], 0);
        chk("directed_valid", o_valid[k], 1);
      end
    end

    // Contention with a free consumer
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      req0_valid = 1'b1; req1_valid = 1'b1; out_ready = 1'b1;
      req0_data = 11'($urandom); req1_data = 11'($urandom);
    end

    // Backpressure then release
    @(posedge clk); #1;
    out_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1 out_ready = 1'b1;
    repeat (3) @(posedge clk);

    for (int i = 0; i < 400; i++) cycle_rand((i < 200) ? 50 : 90);

    // Asynchronous reset with a word held in the output stage
    @(posedge clk); #1;
    req0_valid = 1'b1; req1_valid = 1'b1; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("midrst_out_valid", o_valid[k], 0);
      chk("midrst_out_data", o_data[k], 0);
      chk("midrst_cnt0", o_cnt0[k], 0);
      chk("midrst_cnt1", o_cnt1[k], 0);
    end
    @(negedge clk); #2 rst = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);

    // Counter saturation on the 2-bit instance
    #1 req1_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      req1_data = 11'($urandom);
      @(posedge clk); #1;
    end
    req1_valid = 1'b0;
    @(negedge clk);
    chk("sat_cnt1", o_cnt1[1], 3);
    chk("sat_cnt0", o_cnt0[1], 0);
    chk("rr_cnt1", o_cnt1[0], 6);
    repeat (3) @(posedge clk);

    for (int i = 0; i < 100; i++) cycle_rand(70);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
